// File: rtl/fetch_queue_wires.sv
// Shared types and width helpers for the fetch realignment queue.
// Entries are {pc, halfword}; slots carry one decoded instruction each.
package fetch_queue_wires;

  localparam int unsigned HW_W    = 16;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [HW_W-1:0] hw;
  } ram_entry_type;

  typedef struct packed {
    logic            en;
    logic [PC_W-1:0] pc;
  } ram_in_type;

  typedef ram_entry_type ram_out_type;

  typedef struct packed {
    logic reset;
    logic clear;
    logic fetch_valid;
    logic issue_ready;
  } fetch_queue_in_type;

  typedef struct packed {
    logic               valid;
    logic               comp;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_queue_out_type;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned off_width(input int unsigned fetch_hw);
    return (fetch_hw > 1) ? $clog2(fetch_hw) : 1;
  endfunction

  function automatic logic is_comp(input logic [HW_W-1:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Banked halfword store: one beat-wide synchronous write row, NRD asynchronous
// halfword reads at arbitrary queue addresses (bank = low address bits).
module fetch_queue_ram
  import fetch_queue_wires::*;
#(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NRD      = 4,
  localparam int unsigned PW      = ptr_width(DEPTH),
  localparam int unsigned BW      = $clog2(FETCH_HW),
  localparam int unsigned RW      = PW - BW
) (
  input  logic                     clock,
  input  ram_in_type               wr,
  input  logic [RW-1:0]            wr_row,
  input  logic [HW_W*FETCH_HW-1:0] wr_data,
  input  logic [PW-1:0]            rd_addr [NRD],
  output ram_out_type              rd_data [NRD]
);

  localparam int unsigned ROWS = DEPTH / FETCH_HW;

  ram_entry_type mem [FETCH_HW][ROWS];

  always_ff @(posedge clock) begin
    if (wr.en) begin
      for (int i = 0; i < FETCH_HW; i++) begin
        mem[i][wr_row] <= '{pc: wr.pc + PC_W'(2 * i), hw: wr_data[HW_W*i +: HW_W]};
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign rd_data[j] = mem[rd_addr[j][BW-1:0]][rd_addr[j][PW-1:BW]];
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch realignment queue: buffers fetch beats as halfwords and
// extracts up to ISSUE in-order RV32IC instructions per cycle.
module fetch_queue
  import fetch_queue_wires::*;
#(
  parameter int unsigned FETCH_HW = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ISSUE    = 2,
  parameter logic [31:0] NOP      = 32'h13,
  localparam int unsigned PW      = ptr_width(DEPTH),
  localparam int unsigned CW      = cnt_width(DEPTH),
  localparam int unsigned OW      = off_width(FETCH_HW)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [OW-1:0]         clear_off,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  input  logic [16*FETCH_HW-1:0] fetch_data,
  output logic                  fetch_ready,
  input  logic                  issue_ready,
  output logic [ISSUE-1:0]      out_valid,
  output logic [ISSUE-1:0]      out_comp,
  output logic [32*ISSUE-1:0]   out_pc,
  output logic [32*ISSUE-1:0]   out_instr,
  output logic [CW-1:0]         count
);

  // Slot k starts within the first 2k halfwords, so a 2*ISSUE window covers all slots.
  localparam int unsigned NRD = 2 * ISSUE;
  localparam int unsigned RW  = PW - $clog2(FETCH_HW);

  fetch_queue_in_type  in_s;
  fetch_queue_out_type slot [ISSUE];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, used;
  logic [OW-1:0] skip_q, skip_d;
  logic          wr_en;
  ram_in_type    ram_wr;
  logic [PW-1:0] rd_addr [NRD];
  ram_out_type   win [NRD];

  assign in_s = '{reset: reset, clear: clear, fetch_valid: fetch_valid, issue_ready: issue_ready};

  assign fetch_ready = ~in_s.reset & ~in_s.clear &
                       ((CW'(DEPTH) - count_q) >= CW'(FETCH_HW));
  assign wr_en       = in_s.fetch_valid & fetch_ready;
  assign ram_wr      = '{en: wr_en, pc: fetch_pc};
  assign count       = count_q;

  for (genvar j = 0; j < NRD; j++) begin : g_addr
    assign rd_addr[j] = rptr_q + PW'(j);
  end

  fetch_queue_ram #(
    .FETCH_HW (FETCH_HW),
    .DEPTH    (DEPTH),
    .NRD      (NRD)
  ) u_ram (
    .clock   (clock),
    .wr      (ram_wr),
    .wr_row  (wptr_q[PW-1:PW-RW]),
    .wr_data (fetch_data),
    .rd_addr (rd_addr),
    .rd_data (win)
  );

  // Length decode: each slot begins where the previous valid one ended.
  always_comb begin
    int          off;
    int          size;
    logic        live;
    ram_out_type lo, hi;
    off  = 0;
    live = 1'b1;
    for (int k = 0; k < ISSUE; k++) begin
      lo = win[0];
      hi = win[0];
      for (int j = 0; j < NRD; j++) begin
        if (j == off)     lo = win[j];
        if (j == off + 1) hi = win[j];
      end
      size    = is_comp(lo.hw) ? 1 : 2;
      slot[k] = '{valid: 1'b0, comp: 1'b0, pc: '0, instr: NOP};
      if (live && !in_s.reset && !in_s.clear && int'(count_q) >= off + size) begin
        slot[k] = '{valid: 1'b1, comp: is_comp(lo.hw), pc: lo.pc,
                    instr: is_comp(lo.hw) ? {16'h0, lo.hw} : {hi.hw, lo.hw}};
        off += size;
      end else begin
        live = 1'b0;
      end
    end
    used = in_s.issue_ready ? CW'(off) : '0;
  end

  for (genvar k = 0; k < ISSUE; k++) begin : g_out
    assign out_valid[k]          = slot[k].valid;
    assign out_comp[k]           = slot[k].comp;
    assign out_pc[32*k +: 32]    = slot[k].pc;
    assign out_instr[32*k +: 32] = slot[k].instr;
  end

  // A pending skip only matters for the first beat after a redirect; it is zero otherwise.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q + PW'(used);
    count_d = count_q - used;
    skip_d  = skip_q;
    if (wr_en) begin
      wptr_d  = wptr_q + PW'(FETCH_HW);
      rptr_d  = rptr_d + PW'(skip_q);
      count_d = count_d + CW'(FETCH_HW) - CW'(skip_q);
      skip_d  = '0;
    end
    if (in_s.clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      skip_d  = clear_off;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      skip_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      skip_q  <= skip_d;
    end
  end

endmodule
